// File: rtl/tick_count_ctrl.sv
// Prescaled modulo-N tick counter with start/stop/clear control.
// Counts ticks of DIV clk cycles; continuous wrap or one-shot stop.
module tick_count_ctrl #(
  parameter int DIV = 50_000_000,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         stop,
  input  logic         clr,
  input  logic         oneshot,
  input  logic [W-1:0] mod_n,
  output logic [W-1:0] q,
  output logic         tick,
  output logic         wrap,
  output logic         running,
  output logic         done
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_TC = PW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t         state;
  logic [PW-1:0]  pre;
  logic [W-1:0]   tc;
  logic           os;

  assign running = (state == RUN);
  assign done    = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pre   <= '0;
      q     <= '0;
      tick  <= 1'b0;
      wrap  <= 1'b0;
      tc    <= '0;
      os    <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (clr) begin
        state <= IDLE;
        q     <= '0;
        pre   <= '0;
      end else if (stop) begin
        // stop masks a coincident start; only RUN reacts
        if (state == RUN) state <= PAUSE;
      end else if (start && (state == IDLE || state == DONE)) begin
        state <= RUN;
        q     <= '0;
        pre   <= '0;
        tc    <= mod_n - W'(1);
        os    <= oneshot;
      end else if (start && state == PAUSE) begin
        state <= RUN;
      end else if (state == RUN) begin
        if (pre == PRE_TC) begin
          pre  <= '0;
          tick <= 1'b1;
          if (q == tc) begin
            wrap <= 1'b1;
            if (os) state <= DONE;
            else    q     <= '0;
          end else begin
            q <= q + W'(1);
          end
        end else begin
          pre <= pre + PW'(1);
        end
      end
    end
  end

endmodule

// File: doc/tick_count_ctrl.md
TICK_COUNT_CTRL -- requirements
Module: tick_count_ctrl

Interface
REQ-001 Parameter DIV, default 50_000_000, clk cycles per count tick; legal range 2..2^27-1.
REQ-002 Parameter W, default 4, counter width in bits.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse; begin or resume counting.
REQ-006 stop  input  1  single-cycle pulse; pause counting.
REQ-007 clr  input  1  single-cycle pulse; abort and return to IDLE.
REQ-008 oneshot  input  1  mode select; 0 = continuous wrap, 1 = stop at terminal count.
REQ-009 mod_n  input  W  modulus; count sequence is 0..mod_n-1; value 0 means 2^W.
REQ-010 q  output  W  current count, registered.
REQ-011 tick  output  1  registered one-cycle pulse marking each count event.
REQ-012 wrap  output  1  registered one-cycle pulse when q passes the terminal count.
REQ-013 running  output  1  high only in state RUN.
REQ-014 done  output  1  level, high only in state DONE.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-016 Command priority SHALL be clr > stop > start when pulses coincide.
REQ-017 clr in any state SHALL go to IDLE, set q=0 and clear the prescaler on the next edge.
REQ-018 start in IDLE or DONE SHALL go to RUN, set q=0, clear the prescaler, and latch mod_n and oneshot.
REQ-019 Latched tc SHALL equal mod_n-1 truncated to W bits (mod_n=0 gives tc=2^W-1); mod_n/oneshot changes outside IDLE/DONE->RUN SHALL be ignored.
REQ-020 stop in RUN SHALL go to PAUSE; prescaler and q SHALL hold their values.
REQ-021 start in PAUSE SHALL return to RUN and resume the prescaler from its held value; stop in PAUSE, IDLE or DONE, and start in RUN, SHALL be ignored.
REQ-022 In RUN the prescaler SHALL count 0..DIV-1 and wrap to 0; it SHALL not advance in other states.
REQ-023 tick SHALL assert for the one cycle following the edge where the prescaler equals DIV-1 in RUN; first tick occurs DIV cycles after start.
REQ-024 On each tick event with q!=tc, q SHALL increment by 1 on that same edge.
REQ-025 On a tick event with q==tc and oneshot=0: q SHALL become 0, wrap SHALL pulse, state stays RUN.
REQ-026 On a tick event with q==tc and oneshot=1: q SHALL hold tc, wrap SHALL pulse, state SHALL go DONE.
REQ-027 mod_n=1 SHALL keep q at 0 and pulse wrap on every tick.
REQ-028 stop coinciding with a prescaler terminal cycle SHALL win: no tick, no q change, go PAUSE.
REQ-029 clr coinciding with a terminal tick SHALL win: q=0, no wrap pulse, go IDLE.
REQ-030 Prescaler register SHALL be sized ceil(log2(DIV)) bits; no combinational path from inputs to outputs.

Reset
REQ-031 rst SHALL override all inputs and, on the next edge, set state=IDLE, prescaler=0, q=0, tick=0, wrap=0, running=0, done=0.
REQ-032 rst asserted mid-RUN or mid-PAUSE SHALL discard latched tc/oneshot; a fresh start is required.

Verification (DIV=4, W=4)
REQ-033 rst, start with mod_n=12, oneshot=0 -> tick every 4 cycles; q 0..11, then 0 with wrap pulse on 12th tick; running=1 throughout.
REQ-034 start, mod_n=3, oneshot=1 -> q 0,1,2; wrap pulse and done=1 on 3rd tick; q holds 2; further ticks absent; start again -> q=0, RUN.
REQ-035 RUN with prescaler=2, stop -> PAUSE, q and prescaler frozen 20 cycles; start -> next tick 2 cycles later, not 4.
REQ-036 stop and start same cycle in RUN -> PAUSE; clr and start same cycle in PAUSE -> IDLE, q=0.
REQ-037 mod_n=0 continuous -> q counts 0..15, wrap on 16th tick; mod_n=1 -> q stays 0, wrap every tick.
REQ-038 rst pulsed in RUN at q=5 -> all outputs 0, IDLE; ticks stop until start.
